// File: rtl/gc_relocator.sv
// Static wear-leveling GC relocator: queues cold victims, copies their valid
// pages into a free block, erases the victim and reports the erase.
module gc_relocator #(
   parameter int PAGES  = 64,
   parameter int PAGE_W = 6,
   parameter int BLK_W  = 12,
   parameter int QDEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    gc_req_valid,
   input  logic [BLK_W-1:0]        gc_req_addr,
   output logic                    gc_req_ready,
   input  logic                    free_valid,
   input  logic [BLK_W-1:0]        free_addr,
   output logic                    free_ready,
   output logic                    vm_rd,
   output logic [BLK_W+PAGE_W-1:0] vm_addr,
   input  logic                    vm_rdata,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [1:0]              cmd_op,
   output logic [BLK_W-1:0]        cmd_block,
   output logic [PAGE_W-1:0]       cmd_page,
   input  logic                    cmd_done,
   output logic                    erase_done_en,
   output logic [BLK_W-1:0]        erase_done_addr,
   output logic                    busy,
   output logic [15:0]             moved_cnt
);
   localparam int PTR_W = $clog2(QDEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(QDEPTH);
   localparam logic [1:0] OP_RD = 2'b00, OP_PG = 2'b01, OP_ER = 2'b10;

   typedef enum logic [3:0] {
      IDLE, LOAD, CHECK, CHKWAIT, GETFREE, RD, RDWAIT, PG, PGWAIT, NEXT, ER, ERWAIT, REPORT
   } state_t;

   state_t state_q, state_d;

   logic [BLK_W-1:0]  mem_q [QDEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q, count_d;
   logic              is_dup, push, pop;

   logic [BLK_W-1:0]  victim_q, victim_d, dst_q, dst_d;
   logic [PAGE_W-1:0] page_q, page_d, dst_page_q, dst_page_d;
   logic              have_free_q, have_free_d;
   logic [15:0]       moved_q, moved_d;

   logic                    vm_rd_q, vm_rd_d, free_ready_q, free_ready_d;
   logic [BLK_W+PAGE_W-1:0] vm_addr_q, vm_addr_d;
   logic                    cmd_valid_q, cmd_valid_d;
   logic [1:0]              cmd_op_q, cmd_op_d;
   logic [BLK_W-1:0]        cmd_block_q, cmd_block_d, erase_addr_q, erase_addr_d;
   logic [PAGE_W-1:0]       cmd_page_q, cmd_page_d;
   logic                    erase_en_q, erase_en_d, busy_q, busy_d;

   // A request matching a queued entry or the active victim is accepted but not stored.
   always_comb begin
      logic [PTR_W-1:0] off;
      off    = '0;
      is_dup = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr_q;
         if (({1'b0, off} < count_q) && (mem_q[i] == gc_req_addr)) is_dup = 1'b1;
      end
      if ((state_q != IDLE) && (victim_q == gc_req_addr)) is_dup = 1'b1;
   end

   assign gc_req_ready = (count_q != FULL);
   assign push    = gc_req_valid && gc_req_ready && !is_dup;
   assign pop     = (state_q == IDLE) && (count_q != '0);
   assign count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= gc_req_addr;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         victim_q    <= '0;
         dst_q       <= '0;
         page_q      <= '0;
         dst_page_q  <= '0;
         have_free_q <= 1'b0;
         moved_q     <= '0;
      end else begin
         state_q     <= state_d;
         victim_q    <= victim_d;
         dst_q       <= dst_d;
         page_q      <= page_d;
         dst_page_q  <= dst_page_d;
         have_free_q <= have_free_d;
         moved_q     <= moved_d;
      end
   end

   // Flash command handshake: a command transfers on a cycle where cmd_valid and
   // cmd_ready are both high; until then every cmd field is held; one outstanding.
   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      dst_d       = dst_q;
      page_d      = page_q;
      dst_page_d  = dst_page_q;
      have_free_d = have_free_q;
      moved_d     = moved_q;
      case (state_q)
         IDLE:    if (count_q != '0) begin
                     victim_d = mem_q[rd_ptr_q];
                     state_d  = LOAD;
                  end
         LOAD:    begin
                     page_d      = '0;
                     have_free_d = 1'b0;
                     state_d     = CHECK;
                  end
         CHECK:   state_d = CHKWAIT;
         CHKWAIT: if (!vm_rdata)      state_d = NEXT;
                  else if (have_free_q) state_d = RD;
                  else                 state_d = GETFREE;
         GETFREE: if (free_valid) begin
                     dst_d       = free_addr;
                     dst_page_d  = '0;
                     have_free_d = 1'b1;
                     state_d     = RD;
                  end
         RD:      if (cmd_ready) state_d = RDWAIT;
         RDWAIT:  if (cmd_done)  state_d = PG;
         PG:      if (cmd_ready) state_d = PGWAIT;
         PGWAIT:  if (cmd_done) begin
                     dst_page_d = dst_page_q + 1'b1;
                     moved_d    = moved_q + 16'd1;
                     state_d    = NEXT;
                  end
         NEXT:    if (page_q == PAGE_W'(PAGES - 1)) state_d = ER;
                  else begin
                     page_d  = page_q + 1'b1;
                     state_d = CHECK;
                  end
         ER:      if (cmd_ready) state_d = ERWAIT;
         ERWAIT:  if (cmd_done)  state_d = REPORT;
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_comb begin
      vm_rd_d     = (state_d == CHECK);
      vm_addr_d   = vm_addr_q;
      if (vm_rd_d) vm_addr_d = {victim_d, page_d};
      cmd_valid_d = 1'b0;
      cmd_op_d    = cmd_op_q;
      cmd_block_d = cmd_block_q;
      cmd_page_d  = cmd_page_q;
      case (state_d)
         RD: begin
            cmd_valid_d = 1'b1; cmd_op_d = OP_RD; cmd_block_d = victim_d; cmd_page_d = page_d;
         end
         PG: begin
            cmd_valid_d = 1'b1; cmd_op_d = OP_PG; cmd_block_d = dst_d; cmd_page_d = dst_page_d;
         end
         ER: begin
            cmd_valid_d = 1'b1; cmd_op_d = OP_ER; cmd_block_d = victim_d; cmd_page_d = '0;
         end
         default: ;
      endcase
      free_ready_d = (state_q == GETFREE) && free_valid;
      erase_en_d   = (state_d == REPORT);
      erase_addr_d = erase_addr_q;
      if (erase_en_d) erase_addr_d = victim_d;
      busy_d       = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vm_rd_q      <= 1'b0;
         vm_addr_q    <= '0;
         free_ready_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_op_q     <= '0;
         cmd_block_q  <= '0;
         cmd_page_q   <= '0;
         erase_en_q   <= 1'b0;
         erase_addr_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         vm_rd_q      <= vm_rd_d;
         vm_addr_q    <= vm_addr_d;
         free_ready_q <= free_ready_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_op_q     <= cmd_op_d;
         cmd_block_q  <= cmd_block_d;
         cmd_page_q   <= cmd_page_d;
         erase_en_q   <= erase_en_d;
         erase_addr_q <= erase_addr_d;
         busy_q       <= busy_d;
      end
   end

   assign vm_rd           = vm_rd_q;
   assign vm_addr         = vm_addr_q;
   assign free_ready      = free_ready_q;
   assign cmd_valid       = cmd_valid_q;
   assign cmd_op          = cmd_op_q;
   assign cmd_block       = cmd_block_q;
   assign cmd_page        = cmd_page_q;
   assign erase_done_en   = erase_en_q;
   assign erase_done_addr = erase_addr_q;
   assign busy            = busy_q;
   assign moved_cnt       = moved_q;
endmodule

// File: tb/tb_gc_relocator.sv
// Directed bench for gc_relocator: flash/valid-map responders plus a model that
// derives the expected command stream and erase reports from victims and page maps.
module tb_gc_relocator;
   localparam int PAGES = 64, PAGE_W = 6, BLK_W = 12, QDEPTH = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    gc_req_valid, gc_req_ready;
   logic [BLK_W-1:0]        gc_req_addr;
   logic                    free_valid, free_ready;
   logic [BLK_W-1:0]        free_addr;
   logic                    vm_rd, vm_rdata;
   logic [BLK_W+PAGE_W-1:0] vm_addr;
   logic                    cmd_valid, cmd_ready, cmd_done;
   logic [1:0]              cmd_op;
   logic [BLK_W-1:0]        cmd_block;
   logic [PAGE_W-1:0]       cmd_page;
   logic                    erase_done_en, busy;
   logic [BLK_W-1:0]        erase_done_addr;
   logic [15:0]             moved_cnt;

   gc_relocator #(.PAGES(PAGES), .PAGE_W(PAGE_W), .BLK_W(BLK_W), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst),
      .gc_req_valid(gc_req_valid), .gc_req_addr(gc_req_addr), .gc_req_ready(gc_req_ready),
      .free_valid(free_valid), .free_addr(free_addr), .free_ready(free_ready),
      .vm_rd(vm_rd), .vm_addr(vm_addr), .vm_rdata(vm_rdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_block(cmd_block), .cmd_page(cmd_page), .cmd_done(cmd_done),
      .erase_done_en(erase_done_en), .erase_done_addr(erase_done_addr),
      .busy(busy), .moved_cnt(moved_cnt)
   );

   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0;
   logic [63:0] vmap [int];
   logic [19:0] exp_q [$];
   logic [11:0] exp_er_q [$];
   logic [15:0] exp_mv_q [$];
   int          exp_fr_q [$];
   int          exp_total = 0, exp_fr_total = 0, fr_cnt = 0;
   logic [11:0] cur_free;
   logic        done_block;
   logic        rd_seen = 1'b0, acc_seen = 1'b0;
   logic [17:0] rd_addr_seen = '0;
   logic        prev_valid = 1'b0, prev_ready = 1'b0;
   logic [19:0] prev_cmd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic page_valid(input logic [17:0] a);
      logic [63:0] m;
      m = 64'd0;
      if (vmap.exists(int'(a[17:6]))) m = vmap[int'(a[17:6])];
      return m[a[5:0]];
   endfunction

   // Model: each new victim yields RD/PG pairs for its valid pages, then ER.
   task automatic model_push(input logic [11:0] a);
      logic [63:0] m;
      int          k;
      foreach (exp_er_q[i]) if (exp_er_q[i] == a) return;
      m = 64'd0;
      if (vmap.exists(int'(a))) m = vmap[int'(a)];
      k = 0;
      for (int p = 0; p < PAGES; p++) begin
         if (m[p]) begin
            exp_q.push_back({2'b00, a, 6'(p)});
            exp_q.push_back({2'b01, cur_free, 6'(k)});
            k++;
            exp_total++;
         end
      end
      if (k > 0) exp_fr_total++;
      exp_q.push_back({2'b10, a, 6'd0});
      exp_er_q.push_back(a);
      exp_mv_q.push_back(16'(exp_total));
      exp_fr_q.push_back(exp_fr_total);
   endtask

   // Valid-map and flash responders: data/done arrive the cycle after rd/acceptance.
   always @(negedge clk) begin
      rd_seen      = vm_rd;
      rd_addr_seen = vm_addr;
      acc_seen     = cmd_valid && cmd_ready && rst;
   end
   always @(posedge clk) begin
      #1;
      cmd_done = acc_seen && !done_block;
      vm_rdata = rd_seen ? page_valid(rd_addr_seen) : 1'b0;
   end

   // Compare process.
   always @(negedge clk) begin
      if (!rst) begin
         fr_cnt = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_cmd = '0;
      end else begin
         if (free_ready) fr_cnt++;
         if (cmd_valid && prev_valid && !prev_ready)
            check("cmd_hold", 32'({cmd_op, cmd_block, cmd_page}), 32'(prev_cmd));
         if (prev_valid && prev_ready) check("cmd_drop", 32'(cmd_valid), 32'd0);
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) check("cmd_extra", 32'd1, 32'd0);
            else check("cmd", 32'({cmd_op, cmd_block, cmd_page}), 32'(exp_q.pop_front()));
         end
         if (erase_done_en) begin
            if (exp_er_q.size() == 0) check("erase_extra", 32'd1, 32'd0);
            else begin
               check("erase_addr", 32'(erase_done_addr), 32'(exp_er_q.pop_front()));
               check("moved_at_erase", 32'(moved_cnt), 32'(exp_mv_q.pop_front()));
               check("free_pops", 32'(fr_cnt), 32'(exp_fr_q.pop_front()));
            end
         end
         prev_valid = cmd_valid;
         prev_ready = cmd_ready;
         prev_cmd   = {cmd_op, cmd_block, cmd_page};
      end
   end

   task automatic push_req(input logic [11:0] a);
      int t;
      t = 0;
      @(negedge clk);
      gc_req_valid = 1'b1;
      gc_req_addr  = a;
      while (!gc_req_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!gc_req_ready) begin
         check("push_timeout", 32'd1, 32'd0);
         gc_req_valid = 1'b0;
         return;
      end
      model_push(a);
      @(posedge clk);
      #1 gc_req_valid = 1'b0;
   endtask

   task automatic wait_cmd(input logic [1:0] op);
      int t;
      t = 0;
      @(negedge clk);
      while (!(cmd_valid && cmd_op == op) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!(cmd_valid && cmd_op == op)) check("cmd_wait_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      @(negedge clk);
      while (!(exp_er_q.size() == 0 && !busy) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", 32'(t >= budget), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"},      32'(gc_req_ready), 32'd1);
      check({tag, "_free_ready"}, 32'(free_ready), 32'd0);
      check({tag, "_vm_rd"},      32'(vm_rd), 32'd0);
      check({tag, "_vm_addr"},    32'(vm_addr), 32'd0);
      check({tag, "_cmd_valid"},  32'(cmd_valid), 32'd0);
      check({tag, "_cmd_fields"}, 32'({cmd_op, cmd_block, cmd_page}), 32'd0);
      check({tag, "_erase_en"},   32'(erase_done_en), 32'd0);
      check({tag, "_erase_addr"}, 32'(erase_done_addr), 32'd0);
      check({tag, "_busy"},       32'(busy), 32'd0);
      check({tag, "_moved"},      32'(moved_cnt), 32'd0);
   endtask

   task automatic set_free(input logic [11:0] a);
      cur_free  = a;
      free_addr = a;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; gc_req_valid = 1'b0; gc_req_addr = '0;
      free_valid = 1'b1; cmd_ready = 1'b1; done_block = 1'b0;
      cmd_done = 1'b0; vm_rdata = 1'b0;
      set_free(12'h0AA);
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b1;

      // All-invalid victim: only an erase, no free block.
      push_req(12'h005);
      check("t1_model_len", 32'(exp_q.size()), 32'd1);
      check("t1_model_er", 32'(exp_q[0]), 32'({2'b10, 12'h005, 6'd0}));
      check("t1_busy", 32'(busy), 32'd1);
      wait_idle(1000);
      check("t1_moved", 32'(moved_cnt), 32'd0);
      check("t1_free", 32'(fr_cnt), 32'd0);

      // Sparse copy: pages 3 and 62.
      vmap[12'h010] = (64'd1 << 3) | (64'd1 << 62);
      set_free(12'h100);
      push_req(12'h010);
      check("t2_model_0", 32'(exp_q[0]), 32'({2'b00, 12'h010, 6'd3}));
      check("t2_model_1", 32'(exp_q[1]), 32'({2'b01, 12'h100, 6'd0}));
      check("t2_model_2", 32'(exp_q[2]), 32'({2'b00, 12'h010, 6'd62}));
      check("t2_model_3", 32'(exp_q[3]), 32'({2'b01, 12'h100, 6'd1}));
      check("t2_model_4", 32'(exp_q[4]), 32'({2'b10, 12'h010, 6'd0}));
      wait_idle(2000);
      check("t2_moved", 32'(moved_cnt), 32'd2);
      check("t2_free", 32'(fr_cnt), 32'd1);

      // Queue full plus duplicate, flash stalled.
      @(posedge clk); #1 cmd_ready = 1'b0;
      push_req(12'h001);
      push_req(12'h002);
      push_req(12'h003);
      push_req(12'h004);
      check("t3_ready_not_full", 32'(gc_req_ready), 32'd1);
      push_req(12'h002);
      check("t3_ready_after_dup", 32'(gc_req_ready), 32'd1);
      push_req(12'h005);
      check("t3_ready_full", 32'(gc_req_ready), 32'd0);
      check("t3_model_len", 32'(exp_er_q.size()), 32'd5);
      repeat (5) @(negedge clk);
      check("t3_still_full", 32'(gc_req_ready), 32'd0);
      @(posedge clk); #1 cmd_ready = 1'b1;
      wait_idle(5000);
      check("t3_moved", 32'(moved_cnt), 32'd2);

      // Backpressure on the program command.
      vmap[12'h030] = 64'd1 << 7;
      set_free(12'h300);
      push_req(12'h030);
      wait_cmd(2'b00);
      @(posedge clk); #1 cmd_ready = 1'b0;
      wait_cmd(2'b01);
      repeat (10) begin
         @(negedge clk);
         check("t4_pg_held", 32'(cmd_valid), 32'd1);
      end
      @(posedge clk); #1 cmd_ready = 1'b1;
      wait_idle(2000);
      check("t4_moved", 32'(moved_cnt), 32'd3);

      // Free-block starvation at the first valid page.
      vmap[12'h040] = 64'h6;
      set_free(12'h400);
      @(posedge clk); #1 free_valid = 1'b0;
      push_req(12'h040);
      repeat (30) begin
         @(negedge clk);
         check("t5_starve", 32'({cmd_valid, free_ready}), 32'd0);
      end
      check("t5_busy", 32'(busy), 32'd1);
      @(posedge clk); #1 free_valid = 1'b1;
      wait_idle(2000);
      check("t5_moved", 32'(moved_cnt), 32'd5);
      check("t5_free", 32'(fr_cnt), 32'd3);

      // Reset while waiting for the read to finish.
      vmap[12'h020] = 64'd1 << 5;
      set_free(12'h200);
      @(posedge clk); #1 done_block = 1'b1;
      push_req(12'h020);
      wait_cmd(2'b00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete(); exp_er_q.delete(); exp_mv_q.delete(); exp_fr_q.delete();
      exp_total = 0; exp_fr_total = 0;
      @(negedge clk);
      check_reset_vals("midrst");
      done_block = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      vmap[12'h020] = 64'h21;
      push_req(12'h020);
      check("t6_model_first", 32'(exp_q[0]), 32'({2'b00, 12'h020, 6'd0}));
      wait_idle(2000);
      check("t6_moved", 32'(moved_cnt), 32'd2);

      check("final_cmd_q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
